// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: drives loads/stores over a req/ack data-memory port,
// stalls the front end while an access is outstanding and feeds MEM/WB with a result or a bubble.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [1:0]  ex_sig,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  mw_sig,
  output logic [31:0] mw_rdata,
  output logic [31:0] mw_alu,
  output logic [4:0]  mw_rd,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      sig_q, sig_d;
  logic [31:0]     alu_q, alu_d;
  logic [4:0]      rd_q, rd_d;
  logic            addr_err_q, addr_err_d;
  logic            bus_err_q, bus_err_d;

  logic mem_op;
  logic misaligned;
  logic timeout_hit;

  assign mem_op      = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign misaligned  = (ex_alu[1:0] != 2'b00);
  assign timeout_hit = (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sig_d      = sig_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;

    stall      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    mw_sig     = 2'b00;
    mw_rdata   = 32'h0;
    mw_alu     = 32'h0;
    mw_rd      = 5'd0;

    unique case (state_q)
      StIdle: begin
        if (!mem_op) begin
          mw_sig = ex_valid ? ex_sig : 2'b00;
          mw_alu = ex_alu;
          mw_rd  = ex_rd;
        end else if (misaligned) begin
          addr_err_d = 1'b1;
        end else begin
          stall   = 1'b1;
          we_d    = ex_mem_wr;
          addr_d  = ex_alu;
          wdata_d = ex_wdata;
          // A combined load+store is treated as a store, so nothing may be written back.
          sig_d   = (ex_mem_rd && ex_mem_wr) ? {1'b0, ex_sig[0]} : ex_sig;
          alu_d   = ex_alu;
          rd_d    = ex_rd;
          cnt_d   = '0;
          state_d = StReq;
        end
      end

      StReq: begin
        dmem_req   = 1'b1;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        // An ack on the last allowed cycle still completes the access.
        if (dmem_ack) begin
          mw_sig   = sig_q;
          mw_alu   = alu_q;
          mw_rd    = rd_q;
          mw_rdata = we_q ? 32'h0 : dmem_rdata;
          state_d  = StIdle;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    // Outputs are forced quiet for as long as reset is held.
    if (rst) begin
      stall      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'h0;
      dmem_wdata = 32'h0;
      mw_sig     = 2'b00;
      mw_rdata   = 32'h0;
      mw_alu     = 32'h0;
      mw_rd      = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      sig_q      <= 2'b00;
      alu_q      <= 32'h0;
      rd_q       <= 5'd0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sig_q      <= sig_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign addr_err = addr_err_q;
  assign bus_err  = bus_err_q;

  a_req_aligned : assert property (@(posedge clk) disable iff (rst)
    dmem_req |-> (dmem_addr[1:0] == 2'b00));

  a_stall_bubble : assert property (@(posedge clk) disable iff (rst)
    stall |-> (mw_sig == 2'b00));

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: each instruction is modelled as a timeline of
// MEM-stage cycles derived from its memory latency, against a word-array data memory.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_rd, ex_mem_wr;
  logic [1:0]  ex_sig;
  logic [31:0] ex_alu, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  mw_sig;
  logic [31:0] mw_rdata, mw_alu;
  logic [4:0]  mw_rd;
  logic        addr_err, bus_err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mem [64];
  logic        exp_aerr = 1'b0;
  logic        exp_berr = 1'b0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_mem_rd  (ex_mem_rd),
    .ex_mem_wr  (ex_mem_wr),
    .ex_sig     (ex_sig),
    .ex_alu     (ex_alu),
    .ex_wdata   (ex_wdata),
    .ex_rd      (ex_rd),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .mw_sig     (mw_sig),
    .mw_rdata   (mw_rdata),
    .mw_alu     (mw_alu),
    .mw_rd      (mw_rd),
    .addr_err   (addr_err),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".stall"}, 32'(stall), 32'h0);
    check_eq({tag, ".req"}, 32'(dmem_req), 32'h0);
    check_eq({tag, ".mw_sig"}, 32'(mw_sig), 32'h0);
    check_eq({tag, ".mw_alu"}, mw_alu, 32'h0);
    check_eq({tag, ".mw_rd"}, 32'(mw_rd), 32'h0);
    check_eq({tag, ".mw_rdata"}, mw_rdata, 32'h0);
    check_eq({tag, ".addr_err"}, 32'(addr_err), 32'h0);
    check_eq({tag, ".bus_err"}, 32'(bus_err), 32'h0);
  endtask

  // lat: REQ cycle (1..TO) in which memory acks, 0 = never. rst_at: cycle to assert reset, -1 none.
  task automatic run_instr(input logic v, input logic rd_op, input logic wr_op,
                           input logic [1:0] sig, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] rd, input int lat, input int rst_at);
    logic        mem_op, aligned, in_req, ack_now, last;
    logic [1:0]  e_sig;
    logic [31:0] e_alu, e_rdata;
    logic [4:0]  e_rd;
    int          ncyc;
    int          idx;
    mem_op  = v & (rd_op | wr_op);
    aligned = (alu[1:0] == 2'b00);
    idx     = int'(alu[7:2]);
    if (!mem_op || !aligned) ncyc = 1;
    else ncyc = (lat == 0) ? int'(TO) + 1 : lat + 1;

    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      ex_valid  = v;
      ex_mem_rd = rd_op;
      ex_mem_wr = wr_op;
      ex_sig    = sig;
      ex_alu    = alu;
      ex_wdata  = wd;
      ex_rd     = rd;
      in_req    = mem_op && aligned && t >= 1;
      ack_now   = in_req && lat != 0 && t == lat;
      if (!in_req) dmem_ack = 1'($urandom_range(0, 1));
      else dmem_ack = ack_now;
      dmem_rdata = (ack_now && !wr_op) ? mem[idx] : $urandom;
      #1;
      if (t == rst_at) begin
        rst = 1'b1;
        #1;
        check_quiet("rst_mid");
        @(negedge clk);
        rst       = 1'b0;
        ex_valid  = 1'b0;
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
        dmem_ack  = 1'b0;
        exp_aerr  = 1'b0;
        exp_berr  = 1'b0;
        return;
      end
      last = (t == ncyc - 1);
      if (!mem_op) begin
        e_sig = v ? sig : 2'b00; e_alu = alu; e_rd = rd; e_rdata = 32'h0;
      end else if (aligned && lat != 0 && last) begin
        e_sig   = (rd_op && wr_op) ? {1'b0, sig[0]} : sig;
        e_alu   = alu;
        e_rd    = rd;
        e_rdata = wr_op ? 32'h0 : mem[idx];
      end else begin
        e_sig = 2'b00; e_alu = 32'h0; e_rd = 5'd0; e_rdata = 32'h0;
      end
      check_eq("stall", 32'(stall), 32'(mem_op && aligned && !last));
      check_eq("dmem_req", 32'(dmem_req), 32'(in_req));
      check_eq("mw_sig", 32'(mw_sig), 32'(e_sig));
      check_eq("mw_alu", mw_alu, e_alu);
      check_eq("mw_rd", 32'(mw_rd), 32'(e_rd));
      check_eq("mw_rdata", mw_rdata, e_rdata);
      check_eq("addr_err", 32'(addr_err), 32'(t == 0 && exp_aerr));
      check_eq("bus_err", 32'(bus_err), 32'(t == 0 && exp_berr));
      if (in_req) begin
        check_eq("dmem_we", 32'(dmem_we), 32'(wr_op));
        check_eq("dmem_addr", dmem_addr, alu);
        check_eq("dmem_wdata", dmem_wdata, wd);
      end
    end
    if (mem_op && aligned && lat != 0 && wr_op) mem[idx] = wd;
    exp_aerr = mem_op && !aligned;
    exp_berr = mem_op && aligned && lat == 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst        = 1'b1;
    ex_valid   = 1'b1;
    ex_mem_rd  = 1'b0;
    ex_mem_wr  = 1'b0;
    ex_sig     = 2'b10;
    ex_alu     = 32'h1234;
    ex_wdata   = 32'h0;
    ex_rd      = 5'd5;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst      = 1'b0;
    ex_valid = 1'b0;

    // Directed scenarios.
    run_instr(1'b1, 1'b0, 1'b0, 2'b10, 32'h1234, 32'h0, 5'd5, 0, -1);
    mem[16] = 32'hCAFEF00D;
    run_instr(1'b1, 1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd7, 3, -1);
    run_instr(1'b1, 1'b0, 1'b1, 2'b01, 32'h80, 32'hA5A5A5A5, 5'd3, 1, -1);
    run_instr(1'b1, 1'b1, 1'b0, 2'b11, 32'h42, 32'h0, 5'd9, 1, -1);
    run_instr(1'b1, 1'b1, 1'b0, 2'b11, 32'h44, 32'h0, 5'd10, 0, -1);
    run_instr(1'b1, 1'b1, 1'b0, 2'b11, 32'h48, 32'h0, 5'd11, int'(TO), -1);
    run_instr(1'b1, 1'b1, 1'b1, 2'b11, 32'h4C, 32'h600DBEEF, 5'd12, 2, -1);
    run_instr(1'b1, 1'b1, 1'b0, 2'b11, 32'h4C, 32'h0, 5'd13, 1, -1);
    run_instr(1'b1, 1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd7, 3, 2);
    run_instr(1'b1, 1'b0, 1'b0, 2'b10, 32'h1234, 32'h0, 5'd5, 0, -1);
    run_instr(1'b1, 1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd7, 3, -1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic        v, r, w;
      v = ($urandom_range(0, 7) != 0);
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (r | w) begin
        a = {24'h0, 6'($urandom), 2'b00};
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      end else begin
        a = $urandom;
      end
      run_instr(v, r, w, 2'($urandom), a, $urandom, 5'($urandom),
                int'($urandom_range(0, TO)), ($urandom_range(0, 49) == 0) ? 1 : -1);
    end
    run_instr(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
